// File: rtl/icache_fetch_unit.sv
// -----------------------------------------------------------------------------
// icache_fetch_unit
//
// Direct-mapped instruction cache with its refill controller. It sits between
// the IFU and DDR. Each request returns one line of DATA_W bits, which is a
// fetch group of four 32-bit instructions.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   pc_index_valid/ready  fetch request handshake from the IFU; the PC is
//                         carried on pc_index, and bits [3:0] are ignored
//   pc_operation_done     one-cycle pulse; pc_read_inst holds the fetch group
//                         in that cycle and is 0 in every other cycle
//   redirect_valid        frontend redirect; squashes the in-flight request
//   invalidate_all        fence.i; clears every line valid bit
//   ddr_req_*             refill request (valid/ready); address is line aligned
//   ddr_resp_*            refill response; one beat per request, valid only
//   hit_count/miss_count  saturating 32-bit statistics
// -----------------------------------------------------------------------------
module icache_fetch_unit #(
   parameter int LINES  = 16,
   parameter int PC_W   = 64,
   parameter int DATA_W = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pc_index_valid,
   output logic              pc_index_ready,
   input  logic [PC_W-1:0]   pc_index,
   output logic              pc_operation_done,
   output logic [DATA_W-1:0] pc_read_inst,
   input  logic              redirect_valid,
   input  logic              invalidate_all,
   output logic              ddr_req_valid,
   input  logic              ddr_req_ready,
   output logic [PC_W-1:0]   ddr_req_addr,
   input  logic              ddr_resp_valid,
   input  logic [DATA_W-1:0] ddr_resp_data,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int IDX_W = $clog2(LINES);
   localparam int LA_W  = PC_W - 4;        // line address width, pc[PC_W-1:4]
   localparam int TAG_W = LA_W - IDX_W;

   typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_t;

   state_t              state_reg, state_next;
   logic [LA_W-1:0]     line_addr_reg;
   logic                flush_reg, flush_next;   // redirect seen during the miss
   logic                inval_reg, inval_next;   // invalidate seen during the miss
   logic [LINES-1:0]    valid_reg;
   logic [TAG_W-1:0]    tag_reg  [LINES];
   logic [DATA_W-1:0]   data_reg [LINES];
   logic [31:0]         hit_count_reg, miss_count_reg;

   logic [IDX_W-1:0]    cur_idx;
   logic [TAG_W-1:0]    cur_tag;
   logic                hit;
   logic                ready_c, done_c, req_valid_c, fill_c, hit_inc, miss_inc;
   logic [DATA_W-1:0]   inst_c;
   logic [LINES-1:0]    line_we;
   logic                accept;

   // The offset bits never matter: every request addresses a whole line.
   logic unused_pc_offset;
   assign unused_pc_offset = ^pc_index[3:0];

   assign cur_idx = line_addr_reg[IDX_W-1:0];
   assign cur_tag = line_addr_reg[LA_W-1:IDX_W];
   assign hit     = valid_reg[cur_idx] && (tag_reg[cur_idx] == cur_tag);

   // One write enable per line for the refill write.
   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_line_we
         assign line_we[gi] = fill_c && (cur_idx == IDX_W'(gi));
      end
   endgenerate

   // Next-state and output decode.
   always_comb begin
      state_next  = state_reg;
      flush_next  = flush_reg;
      inval_next  = inval_reg;
      ready_c     = 1'b0;
      done_c      = 1'b0;
      inst_c      = '0;
      req_valid_c = 1'b0;
      fill_c      = 1'b0;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;

      case (state_reg)
         IDLE: begin
            flush_next = 1'b0;
            inval_next = 1'b0;
            ready_c    = !redirect_valid;
            if (pc_index_valid && !redirect_valid) begin
               state_next = LOOKUP;
            end
         end

         LOOKUP: begin
            if (redirect_valid) begin
               state_next = IDLE;
            end else if (hit) begin
               done_c     = 1'b1;
               inst_c     = data_reg[cur_idx];
               hit_inc    = 1'b1;
               state_next = IDLE;
            end else begin
               miss_inc   = 1'b1;
               state_next = MISS_REQ;
            end
         end

         MISS_REQ: begin
            req_valid_c = 1'b1;
            if (redirect_valid) flush_next = 1'b1;
            if (invalidate_all) inval_next = 1'b1;
            if (ddr_req_ready) state_next = MISS_WAIT;
         end

         MISS_WAIT: begin
            if (redirect_valid) flush_next = 1'b1;
            if (invalidate_all) inval_next = 1'b1;
            if (ddr_resp_valid) begin
               fill_c = 1'b1;
               // The response is forwarded to the IFU in the same cycle,
               // unless the request was squashed by a redirect.
               if (!flush_reg && !redirect_valid) begin
                  done_c = 1'b1;
                  inst_c = ddr_resp_data;
               end
               flush_next = 1'b0;
               inval_next = 1'b0;
               state_next = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs are forced low while reset is held.
   assign pc_index_ready    = ready_c && !reset;
   assign pc_operation_done = done_c && !reset;
   assign pc_read_inst      = pc_operation_done ? inst_c : '0;
   assign ddr_req_valid     = req_valid_c && !reset;
   assign ddr_req_addr      = {line_addr_reg, 4'b0000};
   assign hit_count         = hit_count_reg;
   assign miss_count        = miss_count_reg;
   assign accept            = pc_index_ready && pc_index_valid;

   // Control state, valid bits and counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         flush_reg      <= 1'b0;
         inval_reg      <= 1'b0;
         valid_reg      <= '0;
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         flush_reg <= flush_next;
         inval_reg <= inval_next;
         // An invalidate wins over a fill in the same cycle. A fill whose miss
         // overlapped an invalidate writes its data but leaves the line
         // invalid, because the fetched line may predate the fence.
         for (int i = 0; i < LINES; i++) begin
            if (invalidate_all) begin
               valid_reg[i] <= 1'b0;
            end else if (line_we[i] && !inval_reg) begin
               valid_reg[i] <= 1'b1;
            end
         end
         if (hit_inc && (hit_count_reg != 32'hFFFF_FFFF)) begin
            hit_count_reg <= hit_count_reg + 32'd1;
         end
         if (miss_inc && (miss_count_reg != 32'hFFFF_FFFF)) begin
            miss_count_reg <= miss_count_reg + 32'd1;
         end
      end
   end

   // Datapath storage; contents are qualified by valid_reg, so it needs no reset.
   always_ff @(posedge clock) begin
      if (accept) begin
         line_addr_reg <= pc_index[PC_W-1:4];
      end
      for (int i = 0; i < LINES; i++) begin
         if (line_we[i]) begin
            tag_reg[i]  <= cur_tag;
            data_reg[i] <= ddr_resp_data;
         end
      end
   end

endmodule
